// File: rtl/iic_pkg.sv
// Shared constants for the I2C EEPROM-emulating target.
//   ST_*          : FSM state encodings (3-bit, legacy-compatible constants)
//   ACK_LVL       : SDA level meaning acknowledge
//   NACK_LVL      : SDA level meaning not-acknowledge
//   BIT_CNT_LAST  : bit counter value of the 9th (ACK) bit slot
package iic_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DEVADDR = 3'd1;
  localparam logic [2:0] ST_ADDRH   = 3'd2;
  localparam logic [2:0] ST_ADDRL   = 3'd3;
  localparam logic [2:0] ST_WRDATA  = 3'd4;
  localparam logic [2:0] ST_RDDATA  = 3'd5;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  localparam logic [3:0] BIT_CNT_LAST = 4'd8;

endpackage

// File: rtl/iic_slv_sync.sv
// Bus-line synchroniser and event detector for the I2C target.
// Both lines pass through a 2-FF synchroniser; a third stage provides the
// previous value for edge and START/STOP detection.
// Ports:
//   Clk, Rst_n  : system clock, asynchronous active-low reset
//   scl_in      : raw SCL line
//   sda_in      : raw SDA line (resolved bus value)
//   sda         : synchronised SDA level, aligned with the event outputs
//   scl_rise    : 1-Clk pulse on SCL rising edge
//   scl_fall    : 1-Clk pulse on SCL falling edge
//   start_det   : 1-Clk pulse, SDA fell while SCL high
//   stop_det    : 1-Clk pulse, SDA rose while SCL high
module iic_slv_sync (
  input  logic Clk,
  input  logic Rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [2:0] scl_s;
  logic [2:0] sda_s;

  // Reset to the idle bus level (both lines high) so leaving reset never
  // looks like an edge or a START.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], scl_in};
      sda_s <= {sda_s[1:0], sda_in};
    end
  end

  assign sda       = sda_s[1];
  assign scl_rise  =  scl_s[1] & ~scl_s[2];
  assign scl_fall  = ~scl_s[1] &  scl_s[2];
  // SCL must be high in both compared stages so an SDA change that races
  // an SCL edge is not mistaken for a bus condition.
  assign start_det =  scl_s[1] & scl_s[2] & ~sda_s[1] &  sda_s[2];
  assign stop_det  =  scl_s[1] & scl_s[2] &  sda_s[1] & ~sda_s[2];

endmodule

// File: rtl/iic_slave.sv
// I2C target emulating a byte-addressed EEPROM at 7-bit address SLV_ADDR.
// Optional feature macro: IIC_SLV_ADDR16_EN -- when defined, the pointer is
// sent as two bytes (high then low); when undefined, a single pointer byte.
// Ports:
//   Clk, Rst_n  : system clock (>= 16x SCL), asynchronous active-low reset
//   IIC_SCL     : I2C clock, input only (no clock stretching)
//   IIC_SDA     : I2C data, open-drain (driven low or released to z)
//   mem_addr    : byte pointer of the current access (wraps at 2**AW)
//   mem_wdata   : last received data byte
//   mem_we      : 1-Clk write strobe, mem_addr/mem_wdata valid the same cycle
//   mem_re      : 1-Clk read strobe, mem_rdata sampled on the following Clk
//   mem_rdata   : backend read data
//   busy        : high from an addressed START until STOP or read-NACK
//   dbg_state   : current FSM state (ST_* encoding)
// Memory port handshake: there is no ready; the backend must accept every
// mem_we strobe and return mem_rdata exactly one Clk after each mem_re.
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         AW       = 8
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          IIC_SCL,
  inout  wire           IIC_SDA,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  logic       sda_in;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  logic [2:0] state;
  logic [2:0] nxt_st;     // state to enter once the ACK bit completes
  logic [3:0] bit_cnt;    // SCL rises seen in the current byte, 0..8
  logic [7:0] shreg;      // receive shifter, or transmit byte in ST_RDDATA
  logic [7:0] addr_hi;
  logic       ack_en;     // we acknowledge the byte just received
  logic       rd_load;
  logic       scl_fall_d; // delayed fall gives SDA hold time after SCL low
  logic       sda_oe;
  logic [7:0] rx_byte;

  iic_slv_sync u_sync (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .scl_in    (IIC_SCL),
    .sda_in    (IIC_SDA),
    .sda       (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte   = {shreg[6:0], sda_in};
  assign IIC_SDA   = sda_oe ? 1'b0 : 1'bz;
  assign dbg_state = state;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      nxt_st     <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      addr_hi    <= 8'h00;
      ack_en     <= 1'b0;
      rd_load    <= 1'b0;
      scl_fall_d <= 1'b0;
      sda_oe     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      rd_load    <= mem_re;
      scl_fall_d <= scl_fall;
      // Post-increment after each write strobe; a pulse, so one step only.
      if (mem_we) mem_addr <= mem_addr + 1'b1;
      if (rd_load) shreg <= mem_rdata;

      if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= 4'd0;
        ack_en  <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        // Covers repeated START too; mem_addr is deliberately kept.
        state   <= ST_DEVADDR;
        bit_cnt <= 4'd0;
        ack_en  <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (scl_rise && state != ST_IDLE) begin
        if (bit_cnt == BIT_CNT_LAST) begin
          // 9th clock: ACK slot ends.
          bit_cnt <= 4'd0;
          ack_en  <= 1'b0;
          if (state == ST_RDDATA) begin
            if (sda_in == ACK_LVL) begin
              mem_addr <= mem_addr + 1'b1;
              mem_re   <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              busy   <= 1'b0;
              sda_oe <= 1'b0;
            end
          end else begin
            state <= nxt_st;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (state != ST_RDDATA) shreg <= rx_byte;
          if (bit_cnt == 4'd7) begin
            case (state)
              ST_DEVADDR: begin
                if (rx_byte[7:1] == SLV_ADDR) begin
                  ack_en <= 1'b1;
                  busy   <= 1'b1;
                  if (rx_byte[0]) begin
                    mem_re <= 1'b1;
                    nxt_st <= ST_RDDATA;
                  end else begin
`ifdef IIC_SLV_ADDR16_EN
                    nxt_st <= ST_ADDRH;
`else
                    nxt_st <= ST_ADDRL;
`endif
                  end
                end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end
              ST_ADDRH: begin
                addr_hi <= rx_byte;
                ack_en  <= 1'b1;
                nxt_st  <= ST_ADDRL;
              end
              ST_ADDRL: begin
                // Bits above AW are dropped by the cast.
                mem_addr <= AW'({addr_hi, rx_byte});
                ack_en   <= 1'b1;
                nxt_st   <= ST_WRDATA;
              end
              ST_WRDATA: begin
                mem_wdata <= rx_byte;
                mem_we    <= 1'b1;
                ack_en    <= 1'b1;
                nxt_st    <= ST_WRDATA;
              end
              default: ;
            endcase
          end
        end
      end else if (scl_fall_d) begin
        if (state == ST_RDDATA)
          // Transmit MSB first; release for the master's ACK slot.
          sda_oe <= (bit_cnt != BIT_CNT_LAST) && !shreg[3'd7 - bit_cnt[2:0]];
        else
          sda_oe <= (bit_cnt == BIT_CNT_LAST) && ack_en;
      end
    end
  end

endmodule
